// File: rtl/pcihellocore_led_blink_pio.sv
// rtl/pcihellocore_led_blink_pio.sv - LED output PIO with atomic set/clear and prescaled per-bit blinking
module pcihellocore_led_blink_pio #(
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] RESET_VALUE = 32'h0,
   parameter int          DIV_WIDTH   = 24,
   parameter logic [31:0] DIV_RESET   = 32'd12_500_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  blink_tick
);

   localparam logic [DATA_WIDTH-1:0] DATA_INIT = RESET_VALUE[DATA_WIDTH-1:0];
   localparam logic [DIV_WIDTH-1:0]  DIV_INIT  = DIV_RESET[DIV_WIDTH-1:0];

   localparam logic [2:0] A_DATA    = 3'd0;
   localparam logic [2:0] A_BLINK   = 3'd1;
   localparam logic [2:0] A_DIVISOR = 3'd2;
   localparam logic [2:0] A_STATUS  = 3'd3;
   localparam logic [2:0] A_OUTSET  = 3'd4;
   localparam logic [2:0] A_OUTCLR  = 3'd5;

   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] blink;
   logic [DIV_WIDTH-1:0]  divisor;
   logic [DIV_WIDTH-1:0]  cnt;
   logic                  phase;

   logic                  wr;
   logic                  wr_data, wr_blink, wr_div, wr_set, wr_clr;
   logic [DATA_WIDTH-1:0] wd;
   logic [DIV_WIDTH-1:0]  wdiv;
   logic                  toggle;

   assign wr       = chipselect & ~write_n;
   assign wr_data  = wr && (address == A_DATA);
   assign wr_blink = wr && (address == A_BLINK);
   assign wr_div   = wr && (address == A_DIVISOR);
   assign wr_set   = wr && (address == A_OUTSET);
   assign wr_clr   = wr && (address == A_OUTCLR);
   assign wd       = writedata[DATA_WIDTH-1:0];
   assign wdiv     = writedata[DIV_WIDTH-1:0];

   // A DIVISOR write takes priority over a toggle due on the same edge.
   assign toggle     = (divisor != '0) && (cnt == '0) && !wr_div;
   assign blink_tick = toggle & ~reset;

   // LED data register: full write, atomic set, atomic clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        data <= DATA_INIT;
      else if (wr_data) data <= wd;
      else if (wr_set)  data <= data | wd;
      else if (wr_clr)  data <= data & ~wd;
   end

   // Blink mask register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         blink <= '0;
      else if (wr_blink) blink <= wd;
   end

   // Prescaler: counts DIVISOR..0 and toggles phase on the zero cycle; frozen at DIVISOR 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         divisor <= DIV_INIT;
         cnt     <= DIV_INIT;
         phase   <= 1'b0;
      end else if (wr_div) begin
         divisor <= wdiv;
         cnt     <= wdiv;
      end else if (divisor != '0) begin
         if (cnt == '0) begin
            cnt   <= divisor;
            phase <= ~phase;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign out_port = data & ~(blink & {DATA_WIDTH{phase}});

   // Zero-wait combinational read mux; write-only and reserved words read 0.
   always_comb begin
      readdata = '0;
      case (address)
         A_DATA:    readdata = 32'(data);
         A_BLINK:   readdata = 32'(blink);
         A_DIVISOR: readdata = 32'(divisor);
         A_STATUS:  readdata = {phase, 31'b0};
         default:   readdata = '0;
      endcase
   end

endmodule
